// File: rtl/ctrl_pipe_hazard_if.sv
// rtl/ctrl_pipe_hazard_if.sv - decoder-side control/hazard bundle for ctrl_pipe_hazard
interface ctrl_pipe_hazard_if #(
    parameter int REG_W = 5
);
    logic             id_valid;
    logic             id_alusrc;
    logic             id_memtoreg;
    logic             id_regwrite;
    logic             id_memread;
    logic             id_memwrite;
    logic [1:0]       id_aluop;
    logic             id_branch;
    logic [REG_W-1:0] id_rd;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             br_taken;
    logic             stall;
    logic             flush;

    modport master (
        output id_valid, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite,
               id_aluop, id_branch, id_rd, id_rs1, id_rs2, br_taken,
        input  stall, flush
    );

    modport slave (
        input  id_valid, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite,
               id_aluop, id_branch, id_rd, id_rs1, id_rs2, br_taken,
        output stall, flush
    );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// rtl/ctrl_pipe_hazard.sv - ID/EX/MEM/WB control pipeline with load-use stall, flush and forwarding
module ctrl_pipe_hazard #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    ctrl_pipe_hazard_if.slave  dec,
    output logic               ex_alusrc,
    output logic [1:0]         ex_aluop,
    output logic               ex_branch,
    output logic               ex_memread,
    output logic [REG_W-1:0]   ex_rs1,
    output logic [REG_W-1:0]   ex_rs2,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic [REG_W-1:0]   wb_rd,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);
    logic             ex_memtoreg, ex_regwrite, ex_memwrite;
    logic [REG_W-1:0] ex_rd;
    logic             mem_regwrite, mem_memtoreg;
    logic [REG_W-1:0] mem_rd;
    logic             load_use;
    logic             bubble;

    assign load_use = dec.id_valid & ex_memread & (ex_rd != '0) &
                      ((ex_rd == dec.id_rs1) | (ex_rd == dec.id_rs2));
    // A taken branch squashes the dependent instruction anyway, so it masks the stall.
    assign dec.flush = dec.br_taken;
    assign dec.stall = load_use & ~dec.br_taken;
    assign bubble    = dec.stall | dec.flush | ~dec.id_valid;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic             m_wr,
        input logic [REG_W-1:0] m_rd,
        input logic             w_wr,
        input logic [REG_W-1:0] w_rd
    );
        if (m_wr && (m_rd != '0) && (m_rd == rs))      return 2'b10;
        else if (w_wr && (w_rd != '0) && (w_rd == rs)) return 2'b01;
        else                                           return 2'b00;
    endfunction

    assign fwd_a = fwd_sel(ex_rs1, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
    assign fwd_b = fwd_sel(ex_rs2, mem_regwrite, mem_rd, wb_regwrite, wb_rd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_alusrc    <= 1'b0;
            ex_memtoreg  <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_memwrite  <= 1'b0;
            ex_aluop     <= '0;
            ex_branch    <= 1'b0;
            ex_rd        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            mem_regwrite <= 1'b0;
            mem_memtoreg <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_rd       <= '0;
            wb_regwrite  <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_rd        <= '0;
        end else begin
            if (bubble) begin
                ex_alusrc   <= 1'b0;
                ex_memtoreg <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                ex_memwrite <= 1'b0;
                ex_aluop    <= '0;
                ex_branch   <= 1'b0;
                ex_rd       <= '0;
                ex_rs1      <= '0;
                ex_rs2      <= '0;
            end else begin
                ex_alusrc   <= dec.id_alusrc;
                ex_memtoreg <= dec.id_memtoreg;
                ex_regwrite <= dec.id_regwrite;
                ex_memread  <= dec.id_memread;
                ex_memwrite <= dec.id_memwrite;
                ex_aluop    <= dec.id_aluop;
                ex_branch   <= dec.id_branch;
                ex_rd       <= dec.id_rd;
                ex_rs1      <= dec.id_rs1;
                ex_rs2      <= dec.id_rs2;
            end
            mem_regwrite <= ex_regwrite;
            mem_memtoreg <= ex_memtoreg;
            mem_memread  <= ex_memread;
            mem_memwrite <= ex_memwrite;
            mem_rd       <= ex_rd;
            wb_regwrite  <= mem_regwrite;
            wb_memtoreg  <= mem_memtoreg;
            wb_rd        <= mem_rd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (dec.stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (dec.flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// tb/tb_ctrl_pipe_hazard.sv - scoreboard bench for ctrl_pipe_hazard with a stage-list reference model
module tb_ctrl_pipe_hazard;
    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       valid;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic [1:0] aluop;
        logic       branch;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       br;
    } in_t;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [14:0] ex;
        logic [1:0]  mem;
        logic [6:0]  wb;
        logic [3:0]  sc;
        logic [3:0]  fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ctrl_pipe_hazard_if #(.REG_W(REG_W)) ifc ();

    logic             ex_alusrc, ex_branch, ex_memread;
    logic [1:0]       ex_aluop;
    logic [REG_W-1:0] ex_rs1, ex_rs2, wb_rd;
    logic             mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    ctrl_pipe_hazard #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .dec(ifc.slave),
        .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .ex_branch(ex_branch), .ex_memread(ex_memread),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];

    // Reference model: the three in-flight instructions as whole records, plus plain counters.
    in_t m_ex, m_mem, m_wb;
    int  m_scnt, m_fcnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (m_mem.regwrite && m_mem.rd != 0 && m_mem.rd == rs) return 2'b10;
        if (m_wb.regwrite && m_wb.rd != 0 && m_wb.rd == rs)    return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t predict(input in_t i);
        exp_t e;
        e.stall = i.valid && m_ex.memread && m_ex.rd != 0 &&
                  (m_ex.rd == i.rs1 || m_ex.rd == i.rs2) && !i.br;
        e.flush = i.br;
        e.fa    = ref_fwd(m_ex.rs1);
        e.fb    = ref_fwd(m_ex.rs2);
        e.ex    = {m_ex.alusrc, m_ex.aluop, m_ex.branch, m_ex.memread, m_ex.rs1, m_ex.rs2};
        e.mem   = {m_mem.memread, m_mem.memwrite};
        e.wb    = {m_wb.regwrite, m_wb.memtoreg, m_wb.rd};
        e.sc    = 4'(m_scnt);
        e.fc    = 4'(m_fcnt);
        return e;
    endfunction

    task automatic model_step(input in_t i, input exp_t e);
        if (e.stall && m_scnt < CMAX) m_scnt++;
        if (e.flush && m_fcnt < CMAX) m_fcnt++;
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = (e.stall || e.flush || !i.valid) ? '0 : i;
    endtask

    task automatic model_clear();
        m_ex = '0; m_mem = '0; m_wb = '0; m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic drive(input in_t i);
        ifc.id_valid    = i.valid;
        ifc.id_alusrc   = i.alusrc;
        ifc.id_memtoreg = i.memtoreg;
        ifc.id_regwrite = i.regwrite;
        ifc.id_memread  = i.memread;
        ifc.id_memwrite = i.memwrite;
        ifc.id_aluop    = i.aluop;
        ifc.id_branch   = i.branch;
        ifc.id_rd       = i.rd;
        ifc.id_rs1      = i.rs1;
        ifc.id_rs2      = i.rs2;
        ifc.br_taken    = i.br;
    endtask

    function automatic in_t mk(input logic v, input logic mr, input logic rw, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic br);
        in_t i = '0;
        i.valid = v; i.memread = mr; i.memtoreg = mr; i.regwrite = rw;
        i.alusrc = mr; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.br = br;
        return i;
    endfunction

    function automatic in_t rand_in();
        in_t i;
        i.valid    = ($urandom_range(0, 9) < 8);
        i.alusrc   = 1'($urandom);
        i.memtoreg = 1'($urandom);
        i.regwrite = ($urandom_range(0, 9) < 7);
        i.memread  = ($urandom_range(0, 9) < 4);
        i.memwrite = 1'($urandom);
        i.aluop    = 2'($urandom);
        i.branch   = 1'($urandom);
        i.rd       = 5'($urandom_range(0, 3));
        i.rs1      = 5'($urandom_range(0, 3));
        i.rs2      = 5'($urandom_range(0, 3));
        i.br       = ($urandom_range(0, 9) < 2);
        return i;
    endfunction

    function automatic logic [63:0] all_outputs();
        return {26'd0, ifc.stall, ifc.flush, fwd_a, fwd_b, ex_alusrc, ex_aluop, ex_branch, ex_memread,
                ex_rs1, ex_rs2, mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg, wb_rd,
                stall_cnt, flush_cnt};
    endfunction

    in_t  prev_in;
    exp_t prev_e;
    bit   have_prev = 0;

    task automatic run_cycle(input in_t i);
        exp_t e;
        @(posedge clk);
        if (have_prev) model_step(prev_in, prev_e);
        #1;
        drive(i);
        e = predict(i);
        sbq.push_back(e);
        prev_in   = i;
        prev_e    = e;
        have_prev = 1;
    endtask

    // Async reset between clock edges, while the entry pushed this cycle is still pending.
    task automatic mid_reset();
        exp_t e;
        #1 reset = 1'b0;
        drive('0);
        #1;
        chk("async_reset_outputs", all_outputs(), 64'd0);
        sbq.delete();
        model_clear();
        e = predict('0);
        sbq.push_back(e);
        prev_in = '0;
        prev_e  = e;
        #1 reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("stall",     64'(ifc.stall), 64'(e.stall));
            chk("flush",     64'(ifc.flush), 64'(e.flush));
            chk("fwd_a",     64'(fwd_a), 64'(e.fa));
            chk("fwd_b",     64'(fwd_b), 64'(e.fb));
            chk("id_ex",     64'({ex_alusrc, ex_aluop, ex_branch, ex_memread, ex_rs1, ex_rs2}), 64'(e.ex));
            chk("ex_mem",    64'({mem_memread, mem_memwrite}), 64'(e.mem));
            chk("mem_wb",    64'({wb_regwrite, wb_memtoreg, wb_rd}), 64'(e.wb));
            chk("stall_cnt", 64'(stall_cnt), 64'(e.sc));
            chk("flush_cnt", 64'(flush_cnt), 64'(e.fc));
        end
    end

    in_t dir[$];

    initial begin
        drive('0);
        model_clear();
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outputs(), 64'd0);
        reset = 1'b1;

        dir.push_back(mk(1, 1, 1, 5, 1, 0, 0));  // lw x5
        dir.push_back(mk(1, 0, 1, 6, 5, 2, 0));  // dependent add: stall
        dir.push_back(mk(1, 0, 1, 6, 5, 2, 0));  // re-issued after bubble
        dir.push_back(mk(1, 1, 1, 7, 0, 0, 0));  // lw x7
        dir.push_back(mk(1, 0, 1, 8, 7, 7, 1));  // load-use plus taken branch
        dir.push_back(mk(1, 1, 1, 0, 0, 0, 0));  // lw x0
        dir.push_back(mk(1, 0, 1, 9, 0, 0, 0));  // reads x0: no stall
        dir.push_back(mk(1, 1, 1, 4, 0, 0, 0));  // lw x4
        dir.push_back(mk(0, 0, 0, 0, 4, 4, 0));  // invalid ID with matching rs
        dir.push_back(mk(1, 0, 1, 3, 0, 0, 0));
        dir.push_back(mk(1, 0, 1, 3, 0, 0, 0));
        dir.push_back(mk(1, 0, 1, 2, 3, 3, 0));
        dir.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        dir.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        foreach (dir[k]) run_cycle(dir[k]);

        for (int n = 0; n < 400; n++) begin
            run_cycle(rand_in());
            if (n == 200) mid_reset();
        end
        run_cycle('0);
        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
